// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_pkg                                                   |
// | Purpose  : Shared AES types and helpers: FSM state enum, round count,|
// |            Rcon table, GF(2^8) arithmetic and the S-box function.    |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rcon[1..10], entry 1 in the most significant byte.
    localparam logic [79:0] C_RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

    // Number of rounds for a key of nk 32-bit words.
    function automatic int nr(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) begin
            return C_RCON[(10 - int'(idx)) * 8 +: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: multiplicative inverse as
    // x^254 (product of x^2, x^4 .. x^128), then the FIPS-197 affine map.
    // Zero maps to zero in the inverse step, giving sbox(0) = 63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_key_step                                              |
// | Purpose  : Produce key-schedule words w[i..i+3] from the window of   |
// |            the previous NK words w[i-NK..i-1].                       |
// | Ports    : win_i   (NK*32) in  oldest word in the MSBs               |
// |            idx_i   (6)     in  index i of the first new word         |
// |            words_o (128)   out w[i] in the MSBs                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module aes_key_step
    import aes_pkg::*;
#(
    parameter int NK = 6
) (
    input  logic [NK*32-1:0] win_i,
    input  logic [5:0]       idx_i,
    output logic [127:0]     words_o
);
    logic [31:0] w_prev;
    logic [31:0] w_tmp;
    logic [31:0] w_new;
    int          w_j;

    // Four chained expansion steps; any of the four may land on a
    // multiple of NK (NK=6 shifts the boundary every cycle).
    always_comb begin
        words_o = '0;
        w_prev  = win_i[31:0];
        w_tmp   = '0;
        w_new   = '0;
        w_j     = 0;
        for (int k = 0; k < 4; k++) begin
            w_j   = int'(idx_i) + k;
            w_tmp = w_prev;
            if (w_j % NK == 0) begin
                w_tmp = sub_word(rot_word(w_prev)) ^ {rcon(4'(w_j / NK)), 24'h000000};
            end else if (NK == 8 && w_j % 8 == 4) begin
                w_tmp = sub_word(w_prev);
            end
            // w[j-NK] is window position k.
            w_new = win_i[(NK-1-k)*32 +: 32] ^ w_tmp;
            words_o[(3-k)*32 +: 32] = w_new;
            w_prev = w_new;
        end
    end
endmodule
`default_nettype wire

// File: rtl/aes_round_ops.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Modules  : sub_bytes, shift_rows, mix_columns, add_round_key         |
// | Purpose  : The four AES round transforms on a 128-bit state.         |
// |            Byte n of the state is bits [127-8n -: 8]; byte n sits in |
// |            row n%4, column n/4.                                      |
// | Ports    : state_i (128) in, key_i (128) in, state_o (128) out       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign state_o[i*8 +: 8] = sbox(state_i[i*8 +: 8]);
    end
endmodule

module shift_rows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    // Row r rotates left by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign state_o[127 - 8*(r + 4*c) -: 8] =
                state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        end
    end
endmodule

module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign {w_a0, w_a1, w_a2, w_a3} = state_i[127 - 32*c -: 32];
        assign state_o[127 - 32*c -: 32] = {
            xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
            xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
        };
    end
endmodule

module add_round_key (
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);
    assign state_o = state_i ^ key_i;
endmodule
`default_nettype wire

// File: rtl/aes_enc_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : aes_enc_iter                                              |
// | Purpose  : Iterative AES-128/192/256 encryptor, one round per clock, |
// |            key schedule expanded on the fly.                         |
// | Ports    : clk, rst (sync, active high)                              |
// |            in_valid/in_ready, key (NK*32), plaintext (128)   accept  |
// |            out_valid/out_ready, ciphertext (128)             result  |
// |            busy  high whenever not IDLE                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int NK = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NK*32-1:0] key,
    input  logic [127:0]    plaintext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    ciphertext,
    output logic            busy
);
    localparam int NR = nr(NK);
    localparam int WW = NK * 32;

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_enc_iter: NK must be 4, 6 or 8");
    end

    state_t        state_q;
    logic [3:0]    round_q;
    logic [127:0]  data_q;
    logic [WW-1:0] win_q;    // last NK schedule words, oldest in MSBs
    logic [5:0]    widx_q;   // index of the next word to generate

    logic [127:0]  w_sb, w_sr, w_mc, w_mix, w_ark, w_rk, w_new;
    logic          w_last;

    aes_key_step #(.NK(NK)) u_key_step (
        .win_i   (win_q),
        .idx_i   (widx_q),
        .words_o (w_new)
    );

    // The window runs NK+4(r-1) words ahead of w[0], so the round key
    // w[4r..4r+3] is always words 4..7 of {window, new words}. This covers
    // NK=6, where a round key straddles old and freshly generated words.
    assign w_rk   = 128'({win_q, w_new} >> ((NK - 4) * 32));
    assign w_last = (round_q == 4'(NR));

    sub_bytes u_sub_bytes (
        .state_i (data_q),
        .state_o (w_sb)
    );

    shift_rows u_shift_rows (
        .state_i (w_sb),
        .state_o (w_sr)
    );

    mix_columns u_mix_columns (
        .state_i (w_sr),
        .state_o (w_mc)
    );

    assign w_mix = w_last ? w_sr : w_mc;

    add_round_key u_add_round_key (
        .state_i (w_mix),
        .key_i   (w_rk),
        .state_o (w_ark)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            data_q  <= '0;
            win_q   <= '0;
            widx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= plaintext ^ key[WW-1 -: 128];
                        win_q   <= key;
                        widx_q  <= 6'(NK);
                        round_q <= 4'd1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    data_q <= w_ark;
                    win_q  <= WW'({win_q, w_new});
                    widx_q <= widx_q + 6'd4;
                    if (w_last) begin
                        state_q <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        round_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign ciphertext = (state_q == DONE) ? data_q : 128'd0;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_aes_enc_iter                                           |
// | Purpose  : Directed self-checking bench for aes_enc_iter with one    |
// |            instance per key length (NK = 4, 6, 8).                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_aes_enc_iter;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv4, ir4, ov4, or4, bz4;
    logic [127:0] k4, pt4, ct4;
    logic         iv6, ir6, ov6, or6, bz6;
    logic [191:0] k6;
    logic [127:0] pt6, ct6;
    logic         iv8, ir8, ov8, or8, bz8;
    logic [255:0] k8;
    logic [127:0] pt8, ct8;

    aes_enc_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .key(k4),
        .plaintext(pt4), .out_valid(ov4), .out_ready(or4), .ciphertext(ct4), .busy(bz4));
    aes_enc_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .key(k6),
        .plaintext(pt6), .out_valid(ov6), .out_ready(or6), .ciphertext(ct6), .busy(bz6));
    aes_enc_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .key(k8),
        .plaintext(pt8), .out_valid(ov8), .out_ready(or8), .ciphertext(ct8), .busy(bz8));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat4, lat6, lat8, out_n;
        logic [127:0] got4, got6, got8;
        logic         seen;
        int           out_cyc [2];
        logic [127:0] out_ct  [2];

        rst = 1'b1;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        or4 = 1'b1; or6 = 1'b1; or8 = 1'b1;
        k4 = '0; k6 = '0; k8 = '0;
        pt4 = '0; pt6 = '0; pt8 = '0;
        got4 = '0; got6 = '0; got8 = '0;

        // ---- reset state ----
        tick; tick;
        chk_bit("rst_in_ready4", ir4, 1'b1);
        chk_bit("rst_out_valid4", ov4, 1'b0);
        chk_bit("rst_busy4", bz4, 1'b0);
        chk_128("rst_ct4", ct4, 128'd0);
        chk_bit("rst_in_ready6", ir6, 1'b1);
        chk_bit("rst_out_valid6", ov6, 1'b0);
        chk_bit("rst_busy6", bz6, 1'b0);
        chk_128("rst_ct6", ct6, 128'd0);
        chk_bit("rst_in_ready8", ir8, 1'b1);
        chk_bit("rst_out_valid8", ov8, 1'b0);
        chk_bit("rst_busy8", bz8, 1'b0);
        chk_128("rst_ct8", ct8, 128'd0);
        rst = 1'b0;
        tick;

        // ---- FIPS-197 C.1/C.2/C.3 in parallel, inputs scrambled after accept ----
        iv4 = 1'b1; iv6 = 1'b1; iv8 = 1'b1;
        k4 = K128; k6 = K192; k8 = K256;
        pt4 = PT; pt6 = PT; pt8 = PT;
        tick;
        iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
        k4 = ~K128; k6 = ~K192; k8 = ~K256;
        pt4 = ~PT; pt6 = ~PT; pt8 = ~PT;
        chk_bit("round_busy6", bz6, 1'b1);
        chk_bit("round_in_ready6", ir6, 1'b0);
        chk_128("round_ct6_zero", ct6, 128'd0);
        lat4 = -1; lat6 = -1; lat8 = -1;
        for (int cnt = 1; cnt <= 20; cnt++) begin
            tick;
            if (ov4 && lat4 < 0) begin lat4 = cnt; got4 = ct4; end
            if (ov6 && lat6 < 0) begin lat6 = cnt; got6 = ct6; end
            if (ov8 && lat8 < 0) begin lat8 = cnt; got8 = ct8; end
        end
        chk_int("latency_nk4", lat4, 10);
        chk_128("ct_nk4", got4, CT4);
        chk_int("latency_nk6", lat6, 12);
        chk_128("ct_nk6", got6, CT6);
        chk_int("latency_nk8", lat8, 14);
        chk_128("ct_nk8", got8, CT8);
        chk_128("idle_ct4_zero", ct4, 128'd0);
        chk_bit("idle_in_ready8", ir8, 1'b1);

        // ---- back-pressure on NK=6 ----
        or6 = 1'b0;
        iv6 = 1'b1; k6 = K192; pt6 = PT;
        tick;
        iv6 = 1'b0;
        lat6 = -1;
        for (int cnt = 1; cnt <= 20 && lat6 < 0; cnt++) begin
            tick;
            if (ov6) lat6 = cnt;
        end
        chk_int("bp_latency", lat6, 12);
        chk_128("bp_ct", ct6, CT6);
        for (int i = 0; i < 5; i++) begin
            iv6 = (i % 2 == 0);
            k6  = ~K192;
            tick;
            chk_bit("bp_out_valid_hold", ov6, 1'b1);
            chk_128("bp_ct_hold", ct6, CT6);
            chk_bit("bp_in_ready_low", ir6, 1'b0);
        end
        iv6 = 1'b0;
        or6 = 1'b1;
        tick;
        chk_bit("bp_release_out_valid", ov6, 1'b0);
        chk_bit("bp_release_in_ready", ir6, 1'b1);
        chk_128("bp_release_ct", ct6, 128'd0);

        // ---- reset during round 5 on NK=4, with in_valid also high ----
        iv4 = 1'b1; k4 = K128; pt4 = PT;
        tick;
        iv4 = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        iv4 = 1'b1;
        tick;
        rst = 1'b0;
        iv4 = 1'b0;
        chk_bit("abort_in_ready", ir4, 1'b1);
        chk_bit("abort_out_valid", ov4, 1'b0);
        chk_bit("abort_busy", bz4, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            tick;
            if (ov4) seen = 1'b1;
        end
        chk_bit("abort_no_output", seen, 1'b0);
        iv4 = 1'b1; k4 = K128; pt4 = PT;
        tick;
        iv4 = 1'b0;
        lat4 = -1;
        for (int cnt = 1; cnt <= 20 && lat4 < 0; cnt++) begin
            tick;
            if (ov4) begin lat4 = cnt; got4 = ct4; end
        end
        chk_int("post_abort_latency", lat4, 10);
        chk_128("post_abort_ct", got4, CT4);
        tick;

        // ---- back-to-back NK=4 jobs, in_valid held, inputs changed mid-job ----
        out_n = 0;
        out_cyc[0] = -1; out_cyc[1] = -1;
        out_ct[0] = '0; out_ct[1] = '0;
        iv4 = 1'b1; k4 = K128; pt4 = PT;
        tick;
        for (int cnt = 1; cnt <= 30; cnt++) begin
            tick;
            if (ov4 && out_n < 2) begin
                out_cyc[out_n] = cnt;
                out_ct[out_n]  = ct4;
                out_n++;
            end
            if (cnt == 1) begin k4 = KB; pt4 = PTB; end
            if (cnt == 13) begin iv4 = 1'b0; k4 = '1; pt4 = '0; end
        end
        chk_int("b2b_first_cycle", out_cyc[0], 10);
        chk_128("b2b_first_ct", out_ct[0], CT4);
        chk_int("b2b_second_cycle", out_cyc[1], 22);
        chk_128("b2b_second_ct", out_ct[1], CTB);
        chk_int("b2b_count", out_n, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
